// File: rtl/rotate_crossbar_pkg.sv
// rotate_crossbar_pkg
//   Shared constants and helpers for the rotating lane crossbar.
//   - DEF_* : default parameter values for rotate_crossbar / lane_rotator
//   - phase_width : index width for a count, never narrower than 1 bit
//   - rot_src     : source lane feeding output lane j for rotation r
package rotate_crossbar_pkg;

    localparam int DEF_LANES  = 16;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_STEP   = 2;
    localparam int DEF_PHASES = 4;

    // max(1, clog2(n)): a single-value counter still needs one bit of port.
    function automatic int phase_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // dir=0 moves data toward higher lane indices, so output lane j takes
    // input lane j-r; dir=1 is the mirror. r is always < lanes here.
    function automatic int rot_src(input int j, input int r, input logic dir,
                                   input int lanes);
        if (!dir)
            return (j - r + lanes) % lanes;
        else
            return (j + r) % lanes;
    endfunction

endpackage

// File: rtl/rotate_crossbar_lane_rotator.sv
// lane_rotator
//   Purely combinational lane rotation (one mux per output lane).
//   Ports:
//     i_lanes : packed input lanes, lane k at [k*DATA_W +: DATA_W]
//     i_r     : rotation amount, 0 .. LANES-1
//     i_dir   : 0 = toward higher lane index, 1 = toward lower
//     o_lanes : rotated lanes, same packing as i_lanes
module lane_rotator
    import rotate_crossbar_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [LANES*DATA_W-1:0]       i_lanes,
    input  logic [phase_width(LANES)-1:0] i_r,
    input  logic                          i_dir,
    output logic [LANES*DATA_W-1:0]       o_lanes
);

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign o_lanes[gi*DATA_W +: DATA_W] =
                i_lanes[rot_src(gi, int'(i_r), i_dir, LANES)*DATA_W +: DATA_W];
        end
    endgenerate

endmodule

// File: rtl/rotate_crossbar.sv
// rotate_crossbar
//   Registered lane crossbar whose rotation advances by STEP lanes on every
//   accepted beat, cycling through PHASES phases. One-beat output register
//   with valid/ready handshake; 1-cycle latency, 1 beat/cycle throughput.
//   Ports:
//     clk, reset          : clock, synchronous active-high reset
//     io_clk_en           : global enable, 0 freezes all state
//     io_flush            : abort current sequence (phase/valid/status cleared)
//     io_dir              : rotation direction, sampled per beat
//     io_in_valid/ready   : input handshake, io_in packed lanes
//     io_out_valid/ready  : output handshake, io_out packed lanes
//     io_phase            : phase the next accepted beat will use
//     io_done             : pulse after the last phase of a sequence is accepted
//     io_start_next_stage : sticky, a beat was accepted since reset/flush
module rotate_crossbar
    import rotate_crossbar_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int DATA_W = DEF_DATA_W,
    parameter int STEP   = DEF_STEP,
    parameter int PHASES = DEF_PHASES
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           io_clk_en,
    input  logic                           io_flush,
    input  logic                           io_dir,
    input  logic                           io_in_valid,
    output logic                           io_in_ready,
    input  logic [LANES*DATA_W-1:0]        io_in,
    output logic                           io_out_valid,
    input  logic                           io_out_ready,
    output logic [LANES*DATA_W-1:0]        io_out,
    output logic [phase_width(PHASES)-1:0] io_phase,
    output logic                           io_done,
    output logic                           io_start_next_stage
);

    localparam int PW = phase_width(PHASES);
    localparam int RW = phase_width(LANES);

    logic [PW-1:0]           r_phase;
    logic                    r_out_valid;
    logic [LANES*DATA_W-1:0] r_out;
    logic                    r_done;
    logic                    r_started;

    logic                    w_accept;
    logic [RW-1:0]           w_rot;
    logic [LANES*DATA_W-1:0] w_rot_lanes;
    logic                    w_last_phase;

    assign io_in_ready  = io_clk_en & ~io_flush & (~r_out_valid | io_out_ready);
    assign w_accept     = io_in_valid & io_in_ready;
    assign w_last_phase = (r_phase == PW'(PHASES - 1));

    // Product formed in 32-bit arithmetic so the modulo sees the untruncated value.
    assign w_rot = RW'((int'(r_phase) * STEP) % LANES);

    lane_rotator #(
        .LANES  (LANES),
        .DATA_W (DATA_W)
    ) u_lane_rotator (
        .i_lanes (io_in),
        .i_r     (w_rot),
        .i_dir   (io_dir),
        .o_lanes (w_rot_lanes)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase     <= '0;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_done      <= 1'b0;
            r_started   <= 1'b0;
        end else if (io_clk_en) begin
            if (io_flush) begin
                // Data register intentionally left as is.
                r_phase     <= '0;
                r_out_valid <= 1'b0;
                r_done      <= 1'b0;
                r_started   <= 1'b0;
            end else if (w_accept) begin
                r_out       <= w_rot_lanes;
                r_out_valid <= 1'b1;
                r_phase     <= w_last_phase ? '0 : r_phase + PW'(1);
                r_done      <= w_last_phase;
                r_started   <= 1'b1;
            end else begin
                if (io_out_ready)
                    r_out_valid <= 1'b0;
                r_done <= 1'b0;
            end
        end
    end

    assign io_out_valid        = r_out_valid;
    assign io_out              = r_out;
    assign io_phase            = r_phase;
    assign io_done             = r_done;
    assign io_start_next_stage = r_started;

endmodule

// File: tb/tb_rotate_crossbar.sv
// Directed bench for rotate_crossbar: default instance (16 lanes, STEP 2,
// 4 phases) plus an 8-lane, STEP 3, 5-phase instance.
module tb_rotate_crossbar;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, clk_en, flush, dir, out_ready;

    // default instance
    logic         in_valid, in_ready, out_valid, done, started;
    logic [511:0] din, dout;
    logic [1:0]   phase;

    // 8-lane instance
    logic         in_valid8, in_ready8, out_valid8, done8, started8;
    logic [255:0] din8, dout8;
    logic [2:0]   phase8;

    int n_checks = 0;
    int n_fail   = 0;

    rotate_crossbar dut (
        .clk                 (clk),
        .reset               (reset),
        .io_clk_en           (clk_en),
        .io_flush            (flush),
        .io_dir              (dir),
        .io_in_valid         (in_valid),
        .io_in_ready         (in_ready),
        .io_in               (din),
        .io_out_valid        (out_valid),
        .io_out_ready        (out_ready),
        .io_out              (dout),
        .io_phase            (phase),
        .io_done             (done),
        .io_start_next_stage (started)
    );

    rotate_crossbar #(.LANES(8), .DATA_W(32), .STEP(3), .PHASES(5)) dut8 (
        .clk                 (clk),
        .reset               (reset),
        .io_clk_en           (clk_en),
        .io_flush            (flush),
        .io_dir              (dir),
        .io_in_valid         (in_valid8),
        .io_in_ready         (in_ready8),
        .io_in               (din8),
        .io_out_valid        (out_valid8),
        .io_out_ready        (out_ready),
        .io_out              (dout8),
        .io_phase            (phase8),
        .io_done             (done8),
        .io_start_next_stage (started8)
    );

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] lane(input int k);
        return dout[k*32 +: 32];
    endfunction

    function automatic logic [31:0] lane8(input int k);
        return dout8[k*32 +: 32];
    endfunction

    // hand-computed expectations
    int exp_l0_dir0 [4] = '{0, 14, 12, 10};
    int exp_l6_dir0 [4] = '{6, 4, 2, 0};
    int exp_l0_dir1 [4] = '{0, 2, 4, 6};
    int exp_l15_dir1[4] = '{15, 1, 3, 5};
    int exp_l0_8    [5] = '{100 + 0, 100 + 5, 100 + 2, 100 + 7, 100 + 4};

    initial begin
        for (int k = 0; k < 16; k++) din[k*32 +: 32] = 32'(k);
        for (int k = 0; k < 8; k++)  din8[k*32 +: 32] = 32'(100 + k);
        reset = 1'b1; clk_en = 1'b1; flush = 1'b0; dir = 1'b0;
        out_ready = 1'b1; in_valid = 1'b0; in_valid8 = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        $display("reset state");
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_zero",  64'(|dout), 64'd0);
        check_eq("rst_phase",     64'(phase), 64'd0);
        check_eq("rst_done",      64'(done), 64'd0);
        check_eq("rst_started",   64'(started), 64'd0);

        // four beats, dir=0
        in_valid = 1'b1;
        for (int b = 0; b < 4; b++) begin
            check_eq($sformatf("d0_phase_b%0d", b), 64'(phase), 64'(b));
            check_eq($sformatf("d0_ready_b%0d", b), 64'(in_ready), 64'd1);
            tick();
            $display("dir0 beat %0d: lane0=%0d lane6=%0d done=%0b", b, lane(0), lane(6), done);
            check_eq($sformatf("d0_lane0_b%0d", b), 64'(lane(0)), 64'(exp_l0_dir0[b]));
            check_eq($sformatf("d0_lane6_b%0d", b), 64'(lane(6)), 64'(exp_l6_dir0[b]));
            check_eq($sformatf("d0_valid_b%0d", b), 64'(out_valid), 64'd1);
            check_eq($sformatf("d0_done_b%0d", b),  64'(done), 64'(b == 3));
        end
        in_valid = 1'b0;
        check_eq("d0_phase_wrap", 64'(phase), 64'd0);
        check_eq("d0_started", 64'(started), 64'd1);
        tick();
        check_eq("d0_valid_drain", 64'(out_valid), 64'd0);
        check_eq("d0_done_clear",  64'(done), 64'd0);
        check_eq("d0_out_hold",    64'(lane(0)), 64'd10);

        // four beats, dir=1
        dir = 1'b1; in_valid = 1'b1;
        for (int b = 0; b < 4; b++) begin
            tick();
            $display("dir1 beat %0d: lane0=%0d lane15=%0d", b, lane(0), lane(15));
            check_eq($sformatf("d1_lane0_b%0d", b),  64'(lane(0)), 64'(exp_l0_dir1[b]));
            check_eq($sformatf("d1_lane15_b%0d", b), 64'(lane(15)), 64'(exp_l15_dir1[b]));
        end
        in_valid = 1'b0; dir = 1'b0;
        tick();

        // backpressure after beat 1
        in_valid = 1'b1;
        tick();
        check_eq("bp_beat1_lane0", 64'(lane(0)), 64'd0);
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            $display("backpressure cycle %0d: ready=%0b phase=%0d", c, in_ready, phase);
            check_eq($sformatf("bp_ready_c%0d", c), 64'(in_ready), 64'd0);
            tick();
            check_eq($sformatf("bp_hold_c%0d", c),  64'(lane(1)), 64'd1);
            check_eq($sformatf("bp_phase_c%0d", c), 64'(phase), 64'd1);
            check_eq($sformatf("bp_valid_c%0d", c), 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        #1;
        check_eq("bp_ready_release", 64'(in_ready), 64'd1);
        tick();
        $display("backpressure release: lane0=%0d", lane(0));
        check_eq("bp_beat2_lane0", 64'(lane(0)), 64'd14);

        // flush with valid after two beats
        flush = 1'b1;
        #1;
        check_eq("fl_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0;
        $display("flush: valid=%0b started=%0b phase=%0d", out_valid, started, phase);
        check_eq("fl_valid",   64'(out_valid), 64'd0);
        check_eq("fl_started", 64'(started), 64'd0);
        check_eq("fl_phase",   64'(phase), 64'd0);
        check_eq("fl_out_kept", 64'(lane(0)), 64'd14);
        tick();
        check_eq("fl_next_lane0", 64'(lane(0)), 64'd0);
        check_eq("fl_next_lane6", 64'(lane(6)), 64'd6);
        check_eq("fl_restart",    64'(started), 64'd1);

        // finish sequence so done=1, then freeze
        tick(); tick(); tick();
        check_eq("en_pre_done",  64'(done), 64'd1);
        check_eq("en_pre_lane0", 64'(lane(0)), 64'd10);
        clk_en = 1'b0; out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            flush = (c == 2);
            #1;
            check_eq($sformatf("en_ready_c%0d", c), 64'(in_ready), 64'd0);
            tick();
            $display("disabled cycle %0d: done=%0b valid=%0b lane0=%0d", c, done, out_valid, lane(0));
            check_eq($sformatf("en_done_c%0d", c),    64'(done), 64'd1);
            check_eq($sformatf("en_valid_c%0d", c),   64'(out_valid), 64'd1);
            check_eq($sformatf("en_lane0_c%0d", c),   64'(lane(0)), 64'd10);
            check_eq($sformatf("en_started_c%0d", c), 64'(started), 64'd1);
        end
        flush = 1'b0; clk_en = 1'b1; out_ready = 1'b1;
        tick();
        check_eq("en_resume_phase", 64'(phase), 64'd1);
        check_eq("en_resume_lane5", 64'(lane(5)), 64'd5);

        // reset mid-sequence
        reset = 1'b1;
        tick();
        reset = 1'b0;
        $display("mid reset: phase=%0d valid=%0b", phase, out_valid);
        check_eq("mr_out_zero", 64'(|dout), 64'd0);
        check_eq("mr_phase",    64'(phase), 64'd0);
        check_eq("mr_valid",    64'(out_valid), 64'd0);
        check_eq("mr_started",  64'(started), 64'd0);
        tick();
        check_eq("mr_first_lane0", 64'(lane(0)), 64'd0);
        tick();
        check_eq("mr_second_lane0", 64'(lane(0)), 64'd14);
        in_valid = 1'b0;
        tick();

        // 8 lanes, STEP 3, 5 phases
        in_valid8 = 1'b1;
        for (int b = 0; b < 5; b++) begin
            check_eq($sformatf("p5_phase_b%0d", b), 64'(phase8), 64'(b));
            tick();
            $display("8-lane beat %0d: lane0=%0d done=%0b", b, lane8(0), done8);
            check_eq($sformatf("p5_lane0_b%0d", b), 64'(lane8(0)), 64'(exp_l0_8[b]));
            check_eq($sformatf("p5_done_b%0d", b),  64'(done8), 64'(b == 4));
        end
        in_valid8 = 1'b0;
        check_eq("p5_phase_wrap", 64'(phase8), 64'd0);
        check_eq("p5_ready", 64'(in_ready8), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rotate_crossbar.md
ROTATE_CROSSBAR -- requirements
Module: rotate_crossbar

Interface
REQ-001 The block SHALL have parameter LANES, default 16, meaning lane count (>=2).
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning bits per lane.
REQ-003 The block SHALL have parameter STEP, default 2, meaning lanes of rotation added per phase.
REQ-004 The block SHALL have parameter PHASES, default 4, meaning beats per rotation sequence (>=1).
REQ-005 The block SHALL have the ports below, one per line: name  direction  width  meaning.
- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- io_clk_en  in  1  global enable; 0 freezes all state
- io_flush  in  1  abort the current sequence
- io_dir  in  1  0 = rotate toward higher lane index, 1 = toward lower
- io_in_valid  in  1  input beat offered
- io_in_ready  out  1  input beat accepted when high with valid
- io_in  in  LANES*DATA_W  lane k at bits [k*DATA_W +: DATA_W]
- io_out_valid  out  1  output register holds an unconsumed beat
- io_out_ready  in  1  downstream consumes beat
- io_out  out  LANES*DATA_W  rotated lanes, same packing as io_in
- io_phase  out  max(1,clog2(PHASES))  phase the next accepted beat will use
- io_done  out  1  one-cycle pulse: last phase of a sequence accepted
- io_start_next_stage  out  1  sticky: at least one beat accepted since reset/flush
REQ-006 Clock port SHALL be named clk and reset port reset; reset SHALL be synchronous and active-high.

Function
REQ-007 accept = io_clk_en & io_in_valid & io_in_ready & !io_flush.
REQ-008 io_in_ready SHALL equal io_clk_en & !io_flush & (!io_out_valid | io_out_ready) (combinational, no dependency on io_in_valid).
REQ-009 Rotation amount r SHALL be (phase*STEP) mod LANES, computed at full width without truncation before the modulo.
REQ-010 On accept, out lane j SHALL be loaded with in lane (j - r) mod LANES when io_dir=0, or (j + r) mod LANES when io_dir=1; io_dir sampled per beat.
REQ-011 Latency SHALL be 1 cycle: data accepted at edge N is visible on io_out after edge N, io_out_valid=1.
REQ-012 io_out_valid SHALL clear at an edge where io_clk_en & io_out_ready & !accept; SHALL stay 1 when accept and out_ready coincide (back-to-back throughput 1 beat/cycle).
REQ-013 io_out SHALL hold its value whenever no accept occurs, including while io_out_valid=0.
REQ-014 Phase SHALL increment by 1 on each accept and wrap from PHASES-1 to 0; io_done SHALL be 1 for the cycle after the accept of phase PHASES-1, else 0.
REQ-015 With PHASES=1 every accept SHALL use r=0 and pulse io_done.
REQ-016 io_start_next_stage SHALL set on the first accept and remain 1 until reset or flush.
REQ-017 io_flush with io_clk_en=1 SHALL, at the edge: phase<=0, io_out_valid<=0, io_done<=0, io_start_next_stage<=0; io_out unchanged; flush wins over a simultaneous valid.
REQ-018 io_clk_en=0 SHALL hold every register (io_done included) and force io_in_ready=0; flush ignored.

Reset
REQ-019 reset SHALL override io_clk_en and io_flush; at the edge: phase=0, io_out_valid=0, io_done=0, io_start_next_stage=0, io_out=0.
REQ-020 Reset asserted mid-sequence SHALL discard the sequence; the first accept after release SHALL use phase 0.

Structure
REQ-021 Package rotate_crossbar_pkg SHALL hold default parameter constants, the phase-width function and the lane-index rotate function.
REQ-022 One combinational sub-module lane_rotator (inputs: lanes, r, dir; output: rotated lanes) SHALL implement REQ-010; all registers SHALL live in rotate_crossbar.

Verification
REQ-023 Defaults, io_in lane k = k, dir=0, valid held, out_ready=1, 4 beats -> out lane 0 = 0,14,12,10; lane 6 = 6,4,2,0; io_done high only after beat 4; io_phase 0,1,2,3,0.
REQ-024 Same stimulus with dir=1 -> lane 0 = 0,2,4,6; lane 15 = 15,1,3,5.
REQ-025 out_ready=0 after beat 1 for 3 cycles -> io_in_ready=0, io_out holds beat 1, io_phase stays 1; release -> beat 2 uses r=2.
REQ-026 Flush asserted with valid after 2 beats -> no accept, io_out_valid=0, io_start_next_stage=0, next beat uses r=0.
REQ-027 io_clk_en=0 for 5 cycles mid-sequence, then reset mid-sequence -> all outputs frozen while disabled; after reset io_out=0, io_phase=0.
REQ-028 LANES=8, STEP=3, PHASES=5 -> r sequence 0,3,6,1,4 with io_done after beat 5.
